// File: rtl/bin2gray_stream.sv
// Streaming binary-to-Gray encoder with a 2-entry skid buffer on the output.
// Each word carries a flag that says whether it is a single-bit step from the previous word.
module bin2gray_stream #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gray,
    output logic             out_adj,
    output logic [7:0]       out_count
);

    // Handshake: a word moves on a rising edge where valid && ready are both high.
    // The source holds in_bin steady while in_valid && !in_ready.
    // in_ready comes straight from skid occupancy, so it never depends on out_ready.

    logic [WIDTH-1:0] head_gray, skid_gray, last_gray;
    logic             head_adj, skid_adj;
    logic             head_valid, skid_valid;
    logic             first_word;
    logic [7:0]       count;

    logic             in_xfer, out_xfer;
    logic [WIDTH-1:0] new_gray, gray_diff;
    logic             new_adj;

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = head_valid && out_ready;

    assign new_gray  = in_bin ^ (in_bin >> 1);
    assign gray_diff = new_gray ^ last_gray;
    // Exactly one bit differs when the difference is non-zero and a power of two.
    assign new_adj   = !first_word && (gray_diff != '0) &&
                       ((gray_diff & (gray_diff - WIDTH'(1))) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_gray  <= '0;
            head_adj   <= 1'b0;
            head_valid <= 1'b0;
            skid_gray  <= '0;
            skid_adj   <= 1'b0;
            skid_valid <= 1'b0;
            last_gray  <= '0;
            first_word <= 1'b1;
            count      <= 8'd0;
        end else begin
            if (out_xfer) begin
                count <= count + 8'd1;
            end
            if (in_xfer) begin
                last_gray  <= new_gray;
                first_word <= 1'b0;
            end
            // in_xfer cannot happen while the skid is full, so the first branch never drops a word.
            if (out_xfer && skid_valid) begin
                head_gray  <= skid_gray;
                head_adj   <= skid_adj;
                skid_valid <= 1'b0;
            end else if (in_xfer && (!head_valid || out_xfer)) begin
                head_gray  <= new_gray;
                head_adj   <= new_adj;
                head_valid <= 1'b1;
            end else if (in_xfer) begin
                skid_gray  <= new_gray;
                skid_adj   <= new_adj;
                skid_valid <= 1'b1;
            end else if (out_xfer) begin
                head_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = !skid_valid;
    assign out_valid = head_valid;
    assign out_gray  = head_gray;
    assign out_adj   = head_adj;
    assign out_count = count;

endmodule

// File: tb/tb_bin2gray_stream.sv
// Directed bench for bin2gray_stream: vector table, backpressure, random handshake,
// mid-stream reset and output-count wrap.
module tb_bin2gray_stream;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_bin = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_gray;
    logic         out_adj;
    logic [7:0]   out_count;

    bin2gray_stream #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_bin   (in_bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_gray (out_gray),
        .out_adj  (out_adj),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] bin;
        logic [W-1:0] gray;
        logic         adj;
    } vec_t;

    vec_t vecs[20];

    int n_vec  = 0;
    int n_fail = 0;

    // Scoreboard: {adj, gray} of every accepted word, in acceptance order.
    logic [W:0]   exp_q[$];
    logic [W-1:0] m_last;
    logic         m_first;
    int           n_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] gray_of(input logic [W-1:0] b);
        logic [W-1:0] g;
        g[W-1] = b[W-1];
        for (int k = 0; k < W - 1; k++) g[k] = b[k] ^ b[k+1];
        return g;
    endfunction

    function automatic logic adj_of(input logic [W-1:0] a, input logic [W-1:0] b, input logic first);
        int ones;
        ones = 0;
        for (int k = 0; k < W; k++) if (a[k] != b[k]) ones++;
        return !first && (ones == 1);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        m_first   = 1'b1;
        m_last    = '0;
        n_out     = 0;
        exp_q.delete();
    endtask

    initial begin
        logic keep;
        logic [W:0] exp_w;

        vecs[0]  = '{4'h0, 4'h0, 1'b0};
        vecs[1]  = '{4'h1, 4'h1, 1'b1};
        vecs[2]  = '{4'h2, 4'h3, 1'b1};
        vecs[3]  = '{4'h3, 4'h2, 1'b1};
        vecs[4]  = '{4'h4, 4'h6, 1'b1};
        vecs[5]  = '{4'h5, 4'h7, 1'b1};
        vecs[6]  = '{4'h6, 4'h5, 1'b1};
        vecs[7]  = '{4'h7, 4'h4, 1'b1};
        vecs[8]  = '{4'h8, 4'hC, 1'b1};
        vecs[9]  = '{4'h9, 4'hD, 1'b1};
        vecs[10] = '{4'hA, 4'hF, 1'b1};
        vecs[11] = '{4'hB, 4'hE, 1'b1};
        vecs[12] = '{4'hC, 4'hA, 1'b1};
        vecs[13] = '{4'hD, 4'hB, 1'b1};
        vecs[14] = '{4'hE, 4'h9, 1'b1};
        vecs[15] = '{4'hF, 4'h8, 1'b1};
        vecs[16] = '{4'h5, 4'h7, 1'b0};  // 8 -> 7: four bits differ
        vecs[17] = '{4'h9, 4'hD, 1'b0};  // 7 -> D: two bits differ
        vecs[18] = '{4'h8, 4'hC, 1'b1};
        vecs[19] = '{4'h8, 4'hC, 1'b0};  // repeated word: zero bits differ

        // Reset held from time 0: outputs settle with no clock edge yet.
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_gray",  out_gray,  0);
        check("rst_out_adj",   out_adj,   0);
        check("rst_out_count", out_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready",  in_ready,  1);
        check("post_rst_out_valid", out_valid, 0);

        // Vector table, back-to-back with the sink always ready.
        out_ready = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            if (i > 0) begin
                check("tbl_valid", out_valid, 1);
                check("tbl_gray",  out_gray,  vecs[i-1].gray);
                check("tbl_adj",   out_adj,   vecs[i-1].adj);
                check("tbl_count", out_count, i - 1);
            end
            if (i < 20) begin
                in_valid = 1'b1;
                in_bin   = vecs[i].bin;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        check("tbl_final_count", out_count, 20);
        check("tbl_final_valid", out_valid, 0);

        // Backpressure: 3 and 4 fill head and skid, 5 is held until the skid drains.
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bin    = 4'd3;
        @(negedge clk);
        check("bp_in_ready_1", in_ready, 1);
        in_bin = 4'd4;
        @(negedge clk);
        check("bp_in_ready_full", in_ready, 0);
        check("bp_head_first", out_gray, 4'h2);
        in_bin = 4'd5;
        @(negedge clk);
        check("bp_held_ready", in_ready, 0);
        check("bp_head_stable", out_gray, 4'h2);
        check("bp_adj_3", out_adj, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_back", in_ready, 1);
        check("bp_second", out_gray, 4'h6);
        check("bp_adj_4", out_adj, 1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_third", out_gray, 4'h7);
        check("bp_adj_5", out_adj, 1);
        check("bp_third_valid", out_valid, 1);
        @(negedge clk);
        check("bp_drained", out_valid, 0);
        check("bp_count", out_count, 3);

        // Random handshake against the scoreboard.
        do_reset();
        keep = 1'b0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(negedge clk);
            if (!keep) begin
                in_valid = 1'($urandom_range(0, 1));
                in_bin   = W'($urandom_range(0, 15));
            end
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rnd_unexpected_word", 1, 0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("rnd_word", {out_adj, out_gray}, exp_w);
                end
                n_out++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({adj_of(gray_of(in_bin), m_last, m_first), gray_of(in_bin)});
                m_last  = gray_of(in_bin);
                m_first = 1'b0;
            end
            keep = in_valid && !in_ready;
        end
        // Drain with a bounded budget.
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("drain_unexpected_word", 1, 0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("drain_word", {out_adj, out_gray}, exp_w);
                end
                n_out++;
            end
        end
        @(negedge clk);
        check("rnd_queue_empty", exp_q.size(), 0);
        check("rnd_count", out_count, n_out % 256);

        // Reset mid-clock with two words buffered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_bin    = 4'd1;
        @(negedge clk);
        in_bin = 4'd2;
        @(negedge clk);
        in_valid = 1'b0;
        check("mr_full", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", out_valid, 0);
        check("mr_in_ready",  in_ready,  1);
        check("mr_out_gray",  out_gray,  0);
        check("mr_out_count", out_count, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        in_bin    = 4'd3;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("mr_first_gray", out_gray, 4'h2);
        check("mr_first_adj",  out_adj,  0);
        check("mr_first_valid", out_valid, 1);

        // 256 back-to-back transfers wrap the counter.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1;
            in_bin   = W'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("wrap_255", out_count, 255);
        @(negedge clk);
        check("wrap_0", out_count, 0);
        check("wrap_empty", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/bin2gray_stream.md
# bin2gray_stream

Streaming binary-to-Gray encoder with a valid/ready handshake on both sides. It converts each accepted WIDTH-bit binary word to reflected Gray code (g = b ^ (b >> 1)) and buffers results in a 2-entry skid buffer, so the upstream source is never stalled combinationally. Each output word carries a single-bit-step flag, and the block keeps a running count of delivered words. It is the encode-side counterpart of the team's Gray-to-binary code converter and feeds Gray-coded values to downstream logic and converter benches.

## Interface
- WIDTH, 4, bit width of the binary input and the Gray output (minimum 2).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  source presents a word on in_bin.
- in_ready  output  1  block can accept a word this cycle.
- in_bin  input  WIDTH  binary word to encode.
- out_valid  output  1  out_gray/out_adj hold a valid word.
- out_ready  input  1  sink accepts the word this cycle.
- out_gray  output  WIDTH  Gray encoding of the head word.
- out_adj  output  1  head word differs from the previous accepted word's Gray code in exactly one bit.
- out_count  output  8  number of completed output transfers, modulo 256.

## Operation
- Input transfer: in_valid && in_ready at a rising edge. Output transfer: out_valid && out_ready at a rising edge.
- Encoding happens at input transfer: gray = in_bin ^ (in_bin >> 1), with a logical shift and MSB passthrough.
- out_adj is also computed at input transfer:
  - Set to 1 iff popcount(gray ^ last_gray) == 1, where last_gray is the Gray code of the previously accepted word.
  - last_gray is then updated.
  - The first word accepted after reset has out_adj = 0.
  - The flag is stored with its word.
- Storage: output register (head) plus a skid register, each holding {gray, adj, valid}.
- Accepted word placement:
  - If the head is empty, or the head transfers this cycle and the skid is empty, the word goes to the head.
  - Otherwise it goes to the skid.
- On an output transfer with the skid full, the skid word moves to the head. Words always leave in acceptance order.
- in_ready = !skid_valid. It is registered state; there is no combinational path from out_ready to in_ready.
- Simultaneous input and output transfer with a full head and empty skid: the new word replaces the head, and occupancy stays at 1.
- Full condition: head and skid both valid, so in_ready = 0. A word offered on in_valid is not accepted and must be held by the source.
- out_count increments by 1 per output transfer and wraps 255 → 0.
- Values change only at rising edges, except on reset.

## Timing
- Reset (rst_n low, asynchronous): out_valid = 0, out_gray = 0, out_adj = 0, out_count = 0, in_ready = 1, skid empty, last_gray cleared, and the first-word flag set.
- Reset mid-operation discards all buffered words immediately. The first word after reset is treated as the first word.
- Latency: a word accepted at edge N is on out_gray with out_valid = 1 after edge N. This is 1 cycle when unstalled.
- Throughput: 1 word/cycle with out_ready held at 1.
- Stall: with out_ready = 0, at most 2 words are accepted. in_ready drops after the edge that fills the skid. It returns to 1 after the edge at which the skid drains into the head.
- The head word, out_gray, and out_adj are stable while out_valid = 1 and out_ready = 0.
- in_bin is sampled only on an input transfer; its value at other times is ignored.

## Test plan
- Reset values: assert rst_n = 0 mid-clock → outputs reach their reset values without waiting for a clock edge. Release → in_ready = 1, out_valid = 0, out_count = 0.
- Sequential sweep, WIDTH = 4, in_bin = 0..15 back-to-back, out_ready = 1:
  - out_gray = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, each one cycle after its input.
  - out_adj = 0 for the first word, then 1 for all 15 following.
  - out_count = 16 at the end.
- Backpressure: out_ready = 0, offer 3, 4, 5 on consecutive cycles:
  - 3 and 4 are accepted; in_ready = 0 after the second accept; 5 is held.
  - Raise out_ready → outputs are 2 (Gray of 3), 6, 7 in order, with no loss or duplication.
- Non-adjacent words: inputs 5 then 9 → out_gray 7 then D, out_adj 0 then 0 (they differ in 2 bits). Inputs 9 then 8 → out_gray D then C, out_adj 1 for the second word.
- Random handshake: random in_valid and out_ready for 1000 cycles → the output sequence equals the encoded input sequence; a scoreboard matches out_adj; out_count equals the transfer count mod 256.
- Wrap and reset mid-stream:
  - 256 transfers → out_count returns to 0.
  - Reset asserted with 2 words buffered → out_valid = 0 immediately; the next accepted word shows out_adj = 0.
